id_exe_pipe_reg: RTL

//  ID->EXE pipeline register with built-in load-use hazard detection. It latches decoded operands and control

---
 rtl/id_exe_pipe_reg_pkg.sv | 49 ++++
 rtl/id_exe_pipe_reg_if.sv | 53 +++++
 rtl/id_exe_pipe_reg_hazard_detect.sv | 46 ++++
 rtl/id_exe_pipe_reg.sv | 103 ++++++++++
 4 files changed

// File: rtl/id_exe_pipe_reg_pkg.sv
// Shared widths, ALU command encodings and the ID/EXE stage record
// for the ID->EXE pipeline register.
package id_exe_pipe_reg_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CMD_W  = 4;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [CMD_W-1:0] {
        EXE_NOP  = 4'd0,
        EXE_MOV  = 4'd1,
        EXE_ADD  = 4'd2,
        EXE_ADC  = 4'd3,
        EXE_SUB  = 4'd4,
        EXE_SBC  = 4'd5,
        EXE_AND  = 4'd6,
        EXE_ORR  = 4'd7,
        EXE_EOR  = 4'd8,
        EXE_MVN  = 4'd9,
        EXE_LDST = 4'd10
    } exe_cmd_e;

    // One instruction slot as it sits in the ID/EXE register.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [REG_AW-1:0] st_src;
        logic [REG_AW-1:0] dest;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [CMD_W-1:0]  exe_cmd;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] st_val;
        logic [DATA_W-1:0] pc;
    } stage_t;

    // A read collides with a pending write; register 0 is hard-wired and never collides.
    function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] wr,
                                     input logic              wr_en);
        return wr_en && (rd == wr) && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/id_exe_pipe_reg_if.sv
// ID-side inputs and EXE-side outputs of the ID->EXE pipeline register.
// master: the decode stage / environment; slave: the pipeline register.
interface id_exe_pipe_reg_if;
    import id_exe_pipe_reg_pkg::*;

    logic              valid_ID;
    logic [REG_AW-1:0] src1_ID;
    logic [REG_AW-1:0] src2_ID;
    logic [REG_AW-1:0] ST_src_ID;
    logic              use_src2_ID;
    logic [REG_AW-1:0] dest_ID;
    logic              WB_EN_ID;
    logic              MEM_R_EN_ID;
    logic              MEM_W_EN_ID;
    logic [CMD_W-1:0]  EXE_CMD_ID;
    logic [DATA_W-1:0] val1_ID;
    logic [DATA_W-1:0] val2_ID;
    logic [DATA_W-1:0] ST_val_ID;
    logic [DATA_W-1:0] PC_ID;

    logic              valid_EXE;
    logic [REG_AW-1:0] src1_EXE;
    logic [REG_AW-1:0] src2_EXE;
    logic [REG_AW-1:0] ST_src_EXE;
    logic [REG_AW-1:0] dest_EXE;
    logic              WB_EN_EXE;
    logic              MEM_R_EN_EXE;
    logic              MEM_W_EN_EXE;
    logic [CMD_W-1:0]  EXE_CMD_EXE;
    logic [DATA_W-1:0] val1_EXE;
    logic [DATA_W-1:0] val2_EXE;
    logic [DATA_W-1:0] ST_val_EXE;
    logic [DATA_W-1:0] PC_EXE;

    modport master (
        output valid_ID, src1_ID, src2_ID, ST_src_ID, use_src2_ID, dest_ID,
               WB_EN_ID, MEM_R_EN_ID, MEM_W_EN_ID, EXE_CMD_ID,
               val1_ID, val2_ID, ST_val_ID, PC_ID,
        input  valid_EXE, src1_EXE, src2_EXE, ST_src_EXE, dest_EXE,
               WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, EXE_CMD_EXE,
               val1_EXE, val2_EXE, ST_val_EXE, PC_EXE
    );

    modport slave (
        input  valid_ID, src1_ID, src2_ID, ST_src_ID, use_src2_ID, dest_ID,
               WB_EN_ID, MEM_R_EN_ID, MEM_W_EN_ID, EXE_CMD_ID,
               val1_ID, val2_ID, ST_val_ID, PC_ID,
        output valid_EXE, src1_EXE, src2_EXE, ST_src_EXE, dest_EXE,
               WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, EXE_CMD_EXE,
               val1_EXE, val2_EXE, ST_val_EXE, PC_EXE
    );

endinterface

// File: rtl/id_exe_pipe_reg_hazard_detect.sv
// Combinational read-after-write comparator for the instruction in ID.
// Build option FORWARDING_EN: only a load sitting in EXE is a hazard.
// Without it, any pending write in EXE or MEM is a hazard (the register
// file writes in the first half-cycle, so WB never needs a stall).
module id_exe_hazard_detect
    import id_exe_pipe_reg_pkg::*;
(
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic [REG_AW-1:0] st_src,
    input  logic              use_src2,
    input  logic              mem_w_en,
    input  logic [REG_AW-1:0] dest_exe,
    input  logic              wb_en_exe,
    input  logic              mem_r_en_exe,
    input  logic [REG_AW-1:0] dest_mem,
    input  logic              wb_en_mem,
    output logic              hazard_raw
);

    logic rd1_hit;
    logic rd2_hit;
    logic st_hit;

`ifdef FORWARDING_EN
    // Load data is not available until MEM, so only a load in EXE cannot be bypassed.
    logic ld_exe;
    logic unused_mem;

    assign ld_exe     = mem_r_en_exe & wb_en_exe;
    assign unused_mem = ^{dest_mem, wb_en_mem};
    assign rd1_hit    = reg_hit(src1,   dest_exe, ld_exe);
    assign rd2_hit    = reg_hit(src2,   dest_exe, ld_exe);
    assign st_hit     = reg_hit(st_src, dest_exe, ld_exe);
`else
    logic unused_exe;

    assign unused_exe = mem_r_en_exe;
    assign rd1_hit    = reg_hit(src1,   dest_exe, wb_en_exe) | reg_hit(src1,   dest_mem, wb_en_mem);
    assign rd2_hit    = reg_hit(src2,   dest_exe, wb_en_exe) | reg_hit(src2,   dest_mem, wb_en_mem);
    assign st_hit     = reg_hit(st_src, dest_exe, wb_en_exe) | reg_hit(st_src, dest_mem, wb_en_mem);
`endif

    assign hazard_raw = rd1_hit | (use_src2 & rd2_hit) | (mem_w_en & st_hit);

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with load-use hazard detection, bubble
// insertion on hazard/flush, hold on freeze and a saturating stall counter.
// Build option FORWARDING_EN selects the hazard rule in id_exe_hazard_detect.
module id_exe_pipe_reg
    import id_exe_pipe_reg_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                freeze,
    input  logic                flush,
    input  logic [REG_AW-1:0]   dest_MEM,
    input  logic                WB_EN_MEM,
    id_exe_pipe_reg_if.slave    pif,
    output logic                hazard_stall,
    output logic [CNT_W-1:0]    stall_cnt
);

    stage_t id_d;
    stage_t exe_d;
    stage_t exe_q;
    logic   hazard_raw;

    assign id_d = '{
        valid:    pif.valid_ID,
        src1:     pif.src1_ID,
        src2:     pif.src2_ID,
        st_src:   pif.ST_src_ID,
        dest:     pif.dest_ID,
        wb_en:    pif.WB_EN_ID,
        mem_r_en: pif.MEM_R_EN_ID,
        mem_w_en: pif.MEM_W_EN_ID,
        exe_cmd:  pif.EXE_CMD_ID,
        val1:     pif.val1_ID,
        val2:     pif.val2_ID,
        st_val:   pif.ST_val_ID,
        pc:       pif.PC_ID
    };

    id_exe_hazard_detect u_hazard (
        .src1         (pif.src1_ID),
        .src2         (pif.src2_ID),
        .st_src       (pif.ST_src_ID),
        .use_src2     (pif.use_src2_ID),
        .mem_w_en     (pif.MEM_W_EN_ID),
        .dest_exe     (exe_q.dest),
        .wb_en_exe    (exe_q.wb_en),
        .mem_r_en_exe (exe_q.mem_r_en),
        .dest_mem     (dest_MEM),
        .wb_en_mem    (WB_EN_MEM),
        .hazard_raw   (hazard_raw)
    );

    // Flush outranks the hazard; freeze does not mask it so IF/ID also stays put.
    assign hazard_stall = pif.valid_ID & ~flush & hazard_raw;

    // Next-slot select: hold on freeze, all-zero bubble on flush/hazard, else take ID.
    always_comb begin
        exe_d = exe_q;
        if (!freeze) begin
            if (flush || hazard_stall) begin
                exe_d = '0;
            end else begin
                exe_d = id_d;
            end
        end
    end

    // ID/EXE register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q <= '0;
        end else begin
            exe_q <= exe_d;
        end
    end

    // Count hazard bubbles actually inserted; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!freeze && hazard_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign pif.valid_EXE    = exe_q.valid;
    assign pif.src1_EXE     = exe_q.src1;
    assign pif.src2_EXE     = exe_q.src2;
    assign pif.ST_src_EXE   = exe_q.st_src;
    assign pif.dest_EXE     = exe_q.dest;
    assign pif.WB_EN_EXE    = exe_q.wb_en;
    assign pif.MEM_R_EN_EXE = exe_q.mem_r_en;
    assign pif.MEM_W_EN_EXE = exe_q.mem_w_en;
    assign pif.EXE_CMD_EXE  = exe_q.exe_cmd;
    assign pif.val1_EXE     = exe_q.val1;
    assign pif.val2_EXE     = exe_q.val2;
    assign pif.ST_val_EXE   = exe_q.st_val;
    assign pif.PC_EXE       = exe_q.pc;

endmodule
